// File: rtl/video_mode_sequencer.sv
// Video mode sequencer: debounces the analyzer's raw mode, then performs a
// blanked, muted HDMI resync around every committed mode change. Also owns
// HDMI bring-up after PLL lock and recovery after lock loss.
module video_mode_sequencer #(
    parameter int STABLE_FRAMES = 4,
    parameter int MUTE_FRAMES   = 2,
    parameter int RESET_CYCLES  = 16,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       vs_n,
    input  logic [1:0] mode_in,
    output logic [1:0] mode_out,
    output logic       bypass,
    output logic       hdmi_reset,
    output logic       blank,
    output logic       busy
);

    localparam int FRAME_MAX = (STABLE_FRAMES > MUTE_FRAMES) ? STABLE_FRAMES : MUTE_FRAMES;
    localparam int FW        = $clog2(FRAME_MAX + 1);
    localparam int TW        = $clog2(FRAME_TIMEOUT + 1);
    localparam int RW        = $clog2(RESET_CYCLES + 1);

    localparam logic [FW-1:0] STABLE_N = FW'(STABLE_FRAMES);
    localparam logic [FW-1:0] MUTE_N   = FW'(MUTE_FRAMES);
    localparam logic [TW-1:0] TMO_LAST = TW'(FRAME_TIMEOUT - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

    localparam logic [1:0] MODE_MONO = 2'd2;

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_RESET,
        S_BLANK_POST,
        S_RUN,
        S_DEBOUNCE,
        S_BLANK_PRE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    mode_nxt;
    logic [1:0]    cand;
    logic [1:0]    cand_nxt;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_nxt;
    logic [FW-1:0] frame_up;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;
    logic [RW-1:0] rst_cnt;
    logic [RW-1:0] rst_nxt;
    logic          vs_n_p1;
    logic          frame_edge;
    logic          frame_tick;

    // Counters never wrap: they hold at all-ones.
    function automatic logic [FW-1:0] frame_inc(input logic [FW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TW-1:0] tmo_inc(input logic [TW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [RW-1:0] rst_inc(input logic [RW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // vsync delay stage; cleared on reset so no false edge follows reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vs_n_p1 <= 1'b0;
        end else begin
            vs_n_p1 <= vs_n;
        end
    end

    // Frame edge is the falling edge of the active-low vsync.
    assign frame_edge = vs_n_p1 & ~vs_n;

    // Next-state, counter and mode-commit decisions; lock loss overrides all
    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_out;
        cand_nxt   = cand;
        frame_nxt  = frame_cnt;
        frame_up   = frame_inc(frame_cnt);
        tmo_nxt    = '0;
        rst_nxt    = '0;
        frame_tick = 1'b0;

        if (!pll_lock) begin
            state_nxt = S_WAIT_LOCK;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    mode_nxt  = mode_in;
                    state_nxt = S_RESET;
                end

                S_RESET: begin
                    rst_nxt = rst_inc(rst_cnt);
                    if (rst_cnt >= RST_LAST) begin
                        state_nxt = S_BLANK_POST;
                    end
                end

                S_BLANK_POST, S_BLANK_PRE: begin
                    // A missing vsync is replaced by a synthetic frame edge so
                    // the blanked phases always finish.
                    frame_tick = frame_edge || (tmo_cnt >= TMO_LAST);
                    tmo_nxt    = frame_tick ? '0 : tmo_inc(tmo_cnt);
                    if (frame_tick) begin
                        frame_nxt = frame_up;
                        if (frame_up >= MUTE_N) begin
                            if (state == S_BLANK_PRE) begin
                                mode_nxt  = cand;
                                state_nxt = S_RESET;
                            end else begin
                                state_nxt = S_RUN;
                            end
                        end
                    end
                end

                S_RUN: begin
                    if (mode_in != mode_out) begin
                        cand_nxt  = mode_in;
                        frame_nxt = '0;
                        state_nxt = S_DEBOUNCE;
                    end
                end

                S_DEBOUNCE: begin
                    if (mode_in == mode_out) begin
                        state_nxt = S_RUN;
                    end else if (mode_in != cand) begin
                        cand_nxt  = mode_in;
                        frame_nxt = '0;
                    end else if (frame_edge) begin
                        frame_nxt = frame_up;
                        if (frame_up >= STABLE_N) begin
                            state_nxt = S_BLANK_PRE;
                        end
                    end
                end

                default: begin
                    state_nxt = S_WAIT_LOCK;
                end
            endcase
        end

        // Every state starts with fresh counters, so an edge that causes a
        // transition is never counted again in the state it enters.
        if (state_nxt != state) begin
            frame_nxt = '0;
            tmo_nxt   = '0;
            rst_nxt   = '0;
        end
    end

    // State register plus registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_WAIT_LOCK;
            mode_out   <= '0;
            cand       <= '0;
            frame_cnt  <= '0;
            tmo_cnt    <= '0;
            rst_cnt    <= '0;
            bypass     <= 1'b0;
            hdmi_reset <= 1'b1;
            blank      <= 1'b1;
            busy       <= 1'b1;
        end else begin
            state      <= state_nxt;
            mode_out   <= mode_nxt;
            cand       <= cand_nxt;
            frame_cnt  <= frame_nxt;
            tmo_cnt    <= tmo_nxt;
            rst_cnt    <= rst_nxt;
            bypass     <= (mode_nxt == MODE_MONO);
            hdmi_reset <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_RESET);
            blank      <= !((state_nxt == S_RUN) || (state_nxt == S_DEBOUNCE));
            busy       <= (state_nxt != S_RUN);
        end
    end

endmodule

// File: doc/video_mode_sequencer.md
VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 4: consecutive frames a new mode must persist before a switch.
REQ-002 SHALL have parameter MUTE_FRAMES, default 2: blanked frames before and after the HDMI resync.
REQ-003 SHALL have parameter RESET_CYCLES, default 16: hdmi_reset pulse width in clk cycles.
REQ-004 SHALL have parameter FRAME_TIMEOUT, default 1000000: clk cycles without a frame edge after which a frame edge is synthesized.
REQ-005 SHALL have port clk, input, 1: pixel clock; all logic rises on it.
REQ-006 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port pll_lock, input, 1: HDMI PLL locked.
REQ-008 SHALL have port vs_n, input, 1: active-low vsync, in the clk domain.
REQ-009 SHALL have port mode_in, input, 2: raw mode from the video analyzer (0 PAL, 1 NTSC, 2 mono).
REQ-010 SHALL have port mode_out, output, 2: committed mode to the HDMI encoder.
REQ-011 SHALL have port bypass, output, 1: scandoubler bypass, equal to (mode_out==2).
REQ-012 SHALL have port hdmi_reset, output, 1: HDMI encoder resync.
REQ-013 SHALL have port blank, output, 1: forces black RGB and muted audio.
REQ-014 SHALL have port busy, output, 1: high in every state except RUN.

Function
REQ-015 SHALL register all outputs; state changes become visible one cycle after the causing input.
REQ-016 SHALL define a frame edge as a 1->0 transition of vs_n, detected against a one-cycle delayed copy.
REQ-017 SHALL implement states WAIT_LOCK, RESET, BLANK_POST, RUN, DEBOUNCE and BLANK_PRE.
REQ-018 WAIT_LOCK: hdmi_reset=1, blank=1. When pll_lock=1, SHALL latch mode_out<=mode_in and go to RESET.
REQ-019 RESET: hdmi_reset=1, blank=1 for exactly RESET_CYCLES cycles, then go to BLANK_POST.
REQ-020 BLANK_POST: hdmi_reset=0, blank=1. After MUTE_FRAMES frame edges, SHALL go to RUN.
REQ-021 RUN: hdmi_reset=0, blank=0. If mode_in != mode_out, SHALL latch candidate<=mode_in, clear the frame counter and go to DEBOUNCE.
REQ-022 DEBOUNCE: outputs as in RUN.
  - mode_in==mode_out: return to RUN, no switch.
  - mode_in differs from both mode_out and candidate: reload candidate and clear the count.
  - Otherwise each frame edge increments the count; when the count reaches STABLE_FRAMES, go to BLANK_PRE.
REQ-023 BLANK_PRE: blank=1, hdmi_reset=0. After MUTE_FRAMES frame edges, SHALL set mode_out<=candidate and go to RESET.
REQ-024 In BLANK_PRE, changes of mode_in SHALL be ignored; the candidate is frozen.
REQ-025 In BLANK_PRE and BLANK_POST, a cycle counter SHALL clear on each frame edge.
  - On reaching FRAME_TIMEOUT the counter SHALL count as a frame edge and clear.
  - Loss of vsync therefore never stalls the sequence.
REQ-026 pll_lock=0 in any state SHALL force WAIT_LOCK on the next cycle. This has priority over all other transitions.
REQ-027 A frame edge coincident with a state entry SHALL NOT be counted in the new state.
REQ-028 Counters SHALL saturate, never wrap. Widths: frame counters clog2(max(STABLE_FRAMES,MUTE_FRAMES)+1); timeout counter clog2(FRAME_TIMEOUT+1).
REQ-029 bypass SHALL change only together with mode_out, i.e. only while blank=1.

Reset
REQ-030 resetn=0 at a clk edge SHALL give state WAIT_LOCK, mode_out=0, bypass=0, hdmi_reset=1, blank=1, busy=1, candidate=0 and all counters 0.
REQ-031 resetn=0 mid-sequence (any state) SHALL abort the sequence with the same values and no partial mode commit.

Verification
Parameters for all scenarios: STABLE_FRAMES=2, MUTE_FRAMES=1, RESET_CYCLES=4, FRAME_TIMEOUT=100.
REQ-032 Bring-up: reset, then pll_lock=1 with mode_in=1.
  - mode_out=1 and hdmi_reset=1 for exactly 4 cycles.
  - blank falls one cycle after the first frame edge that follows.
  - busy=0.
REQ-033 Glitch: in RUN with mode_out=0, mode_in=2 for 1 frame then back to 0.
  - blank stays 0, hdmi_reset stays 0, mode_out stays 0.
REQ-034 Switch: in RUN with mode_out=0, mode_in=2 held.
  - After 2 frame edges, blank=1.
  - After 1 more frame edge, mode_out=2, bypass=1, hdmi_reset pulses for 4 cycles.
  - blank=0 after the next frame edge.
REQ-035 Timeout: in BLANK_PRE, vs_n held high.
  - The mode commits 100 cycles after BLANK_PRE entry.
  - In BLANK_POST, blank clears 100 cycles later.
REQ-036 Lock loss: pll_lock=0 during DEBOUNCE.
  - Next cycle: WAIT_LOCK, hdmi_reset=1, blank=1.
  - On relock, mode_out = mode_in sampled at relock.
REQ-037 Reset mid-RESET state: resetn=0 for 1 cycle.
  - All outputs at reset values.
  - The sequence restarts from WAIT_LOCK.
